// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: RV32I load/store funct3
// encodings, FSM state enum, legality and byte-lane/replication helpers.
package lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_t;

  function automatic logic f3_legal(input logic i_we, input logic [2:0] i_f3);
    if (i_we) begin
      return (i_f3 == LSU_B) || (i_f3 == LSU_H) || (i_f3 == LSU_W);
    end
    return (i_f3 == LSU_B) || (i_f3 == LSU_H) || (i_f3 == LSU_W) ||
           (i_f3 == LSU_BU) || (i_f3 == LSU_HU);
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] i_f3, input logic [1:0] i_off);
    return ((i_f3[1:0] == 2'b01) && i_off[0]) ||
           ((i_f3[1:0] == 2'b10) && (i_off != 2'b00));
  endfunction

  // Halfwords only look at off[1], so a misaligned H quietly snaps to its half.
  function automatic logic [3:0] lane_be(input logic [2:0] i_f3, input logic [1:0] i_off);
    logic [3:0] be;
    case (i_f3[1:0])
      2'b00:   be = 4'b0001 << i_off;
      2'b01:   be = i_off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_rep(input logic [2:0] i_f3, input logic [31:0] i_wd);
    logic [31:0] rep;
    case (i_f3[1:0])
      2'b00:   rep = {4{i_wd[7:0]}};
      2'b01:   rep = {2{i_wd[15:0]}};
      default: rep = i_wd;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load formatter: picks the byte/halfword addressed by the low address bits
// out of the returned word and sign- or zero-extends it by funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_off)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    case (i_funct3)
      LSU_B:   o_data = {{24{w_byte[7]}}, w_byte};
      LSU_BU:  o_data = {24'h000000, w_byte};
      LSU_H:   o_data = {{16{w_half[15]}}, w_half};
      LSU_HU:  o_data = {16'h0000, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one load/store per request over a req/ack bus, with a
// bus watchdog. Define MISALIGN_TRAP_EN to trap misaligned H/W accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 255
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic             i_req_we,
  input  logic [2:0]       i_req_funct3,
  input  logic [WIDTH-1:0] i_req_addr,
  input  logic [WIDTH-1:0] i_req_wdata,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic [WIDTH-1:0] o_mem_addr,
  output logic [3:0]       o_mem_be,
  output logic [WIDTH-1:0] o_mem_wdata,
  input  logic             i_mem_ack,
  input  logic [WIDTH-1:0] i_mem_rdata,
  output logic             o_rsp_valid,
  output logic [WIDTH-1:0] o_rsp_rdata,
  output logic             o_rsp_err
);

  localparam int unsigned WDW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned WD_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [WDW-1:0] WD_LAST = WD_LAST_I[WDW-1:0];

  lsu_state_t       r_state;
  lsu_state_t       w_state_next;
  logic             r_we;
  logic [2:0]       r_funct3;
  logic [1:0]       r_off;
  logic [WIDTH-1:0] r_addr;
  logic [3:0]       r_be;
  logic [WIDTH-1:0] r_wdata;
  logic [WIDTH-1:0] r_rword;
  logic             r_err;
  logic [WDW-1:0]   r_wdog;

  logic             w_accept;
  logic             w_req_err;
  logic             w_timeout;
  logic [WIDTH-1:0] w_load_data;

  assign w_accept = (r_state == ST_IDLE) && i_req_valid;

`ifdef MISALIGN_TRAP_EN
  assign w_req_err = !f3_legal(i_req_we, i_req_funct3) ||
                     f3_misaligned(i_req_funct3, i_req_addr[1:0]);
`else
  assign w_req_err = !f3_legal(i_req_we, i_req_funct3);
`endif

  // Fires on the last allowed BUS cycle; an ack on that same edge still wins.
  assign w_timeout = (TIMEOUT != 0) && (r_state == ST_BUS) && (r_wdog == WD_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_req_valid) begin
          w_state_next = w_req_err ? ST_RESP : ST_BUS;
        end
      end
      ST_BUS: begin
        if (i_mem_ack || w_timeout) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_req_ready = (r_state == ST_IDLE);
    o_mem_req   = (r_state == ST_BUS);
    o_mem_we    = (r_state == ST_BUS) && r_we;
    o_mem_addr  = (r_state == ST_BUS) ? r_addr  : '0;
    o_mem_be    = (r_state == ST_BUS) ? r_be    : 4'b0000;
    o_mem_wdata = (r_state == ST_BUS) ? r_wdata : '0;
    o_rsp_valid = (r_state == ST_RESP);
    o_rsp_err   = (r_state == ST_RESP) && r_err;
    o_rsp_rdata = ((r_state == ST_RESP) && !r_err && !r_we) ? w_load_data : '0;
  end

  // Request capture, read-word latch and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_off    <= 2'b00;
      r_addr   <= '0;
      r_be     <= 4'b0000;
      r_wdata  <= '0;
      r_rword  <= '0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_we     <= i_req_we;
      r_funct3 <= i_req_funct3;
      r_off    <= i_req_addr[1:0];
      r_addr   <= {i_req_addr[WIDTH-1:2], 2'b00};
      r_be     <= lane_be(i_req_funct3, i_req_addr[1:0]);
      r_wdata  <= store_rep(i_req_funct3, i_req_wdata);
      r_rword  <= '0;
      r_err    <= w_req_err;
    end else if (r_state == ST_BUS) begin
      if (i_mem_ack) begin
        r_rword <= i_mem_rdata;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  // Watchdog counts BUS cycles and clears whenever the bus is idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
    end else if ((r_state == ST_BUS) && !i_mem_ack && (TIMEOUT != 0)) begin
      r_wdog <= r_wdog + 1'b1;
    end else begin
      r_wdog <= '0;
    end
  end

  lsu_load_align u_align (
    .i_funct3 (r_funct3),
    .i_off    (r_off),
    .i_word   (r_rword),
    .o_data   (w_load_data)
  );

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// loads/stores scored against an arithmetic reference model.
module tb_load_store_unit;

  localparam int TB_TIMEOUT = 6;

  logic        clk;
  logic        rst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [2:0]  i_req_funct3;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit #(.WIDTH(32), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_we     (i_req_we),
    .i_req_funct3 (i_req_funct3),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_be     (o_mem_be),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_ack    (i_mem_ack),
    .i_mem_rdata  (i_mem_rdata),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_rdata  (o_rsp_rdata),
    .o_rsp_err    (o_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_time_limit reached: simulation did not finish, required finish");
    $fatal(1, "time limit");
  end

  // Reference model built from the access rules with plain arithmetic.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rd,
                                output logic bus, output logic err, output logic [3:0] be,
                                output logic [31:0] wdata, output logic [31:0] rdata);
    int unsigned off, hoff, size, v;
    logic legal, mis;
    off  = addr % 4;
    size = f3 % 4;
    if (we) legal = (f3 <= 2);
    else    legal = (f3 <= 2) || (f3 == 4) || (f3 == 5);
    mis = (size == 1 && (off % 2) == 1) || (size == 2 && off != 0);
`ifdef MISALIGN_TRAP_EN
    err = !legal || mis;
`else
    err = !legal;
`endif
    bus  = !err;
    hoff = off & 2;
    if (size == 0) begin
      be    = 4'(1 << off);
      wdata = (wd % 256) * 32'h0101_0101;
      v     = (rd >> (8 * off)) % 256;
      if (f3 < 4 && v >= 128) v = v - 256;
    end else if (size == 1) begin
      be    = 4'(3 << hoff);
      wdata = (wd % 65536) * 32'h0001_0001;
      v     = (rd >> (8 * hoff)) % 65536;
      if (f3 < 4 && v >= 32768) v = v - 65536;
    end else begin
      be    = 4'hF;
      wdata = wd;
      v     = rd;
    end
    rdata = v;
  endfunction

  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int delay);
    logic        exp_bus, exp_err, got;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_rd, exp_addr;
    int          n, exp_cycles;
    model(we, f3, addr, wd, rd, exp_bus, exp_err, exp_be, exp_wd, exp_rd);
    exp_addr = addr - (addr % 4);
    if (exp_bus && delay >= TB_TIMEOUT) exp_err = 1'b1;
    if (exp_err || we) exp_rd = 32'h0;
    exp_cycles = (delay < TB_TIMEOUT) ? delay + 1 : TB_TIMEOUT;

    @(negedge clk);
    n_checks++;
    if (o_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL req_ready_idle got=%b exp=1", o_req_ready);
    end
    i_req_valid = 1'b1; i_req_we = we; i_req_funct3 = f3;
    i_req_addr = addr; i_req_wdata = wd;
    @(negedge clk);
    i_req_valid = 1'b0; i_req_we = $urandom; i_req_funct3 = 3'($urandom);
    i_req_addr = $urandom; i_req_wdata = $urandom;

    n = 0; got = 1'b0;
    if (exp_bus) begin
      while (!got && n < TB_TIMEOUT + 4) begin
        if (o_rsp_valid === 1'b1) begin
          got = 1'b1;
        end else begin
          n_checks++;
          if (o_mem_req !== 1'b1 || o_mem_we !== we || o_mem_addr !== exp_addr ||
              o_mem_be !== exp_be || o_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bus_cycle%0d got req=%b we=%b addr=%h be=%b rdy=%b exp req=1 we=%b addr=%h be=%b rdy=0",
                     n, o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_req_ready, we, exp_addr, exp_be);
          end
          if (we) begin
            n_checks++;
            if (o_mem_wdata !== exp_wd) begin
              n_fail++; $display("FAIL mem_wdata got=%h exp=%h", o_mem_wdata, exp_wd);
            end
          end
          if (n == delay && delay < TB_TIMEOUT) begin
            i_mem_ack = 1'b1; i_mem_rdata = rd;
          end
          @(negedge clk);
          i_mem_ack = 1'b0; i_mem_rdata = $urandom;
          n++;
        end
      end
      n_checks++;
      if (!got || n != exp_cycles) begin
        n_fail++; $display("FAIL bus_length got_rsp=%b cycles=%0d exp_cycles=%0d", got, n, exp_cycles);
      end
    end

    n_checks++;
    if (o_rsp_valid !== 1'b1 || o_rsp_err !== exp_err || o_rsp_rdata !== exp_rd ||
        o_mem_req !== 1'b0 || o_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL response got valid=%b err=%b rdata=%h req=%b rdy=%b exp valid=1 err=%b rdata=%h req=0 rdy=0",
               o_rsp_valid, o_rsp_err, o_rsp_rdata, o_mem_req, o_req_ready, exp_err, exp_rd);
    end
    @(negedge clk);
    n_checks++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rsp_one_cycle got valid=%b rdy=%b exp valid=0 rdy=1", o_rsp_valid, o_req_ready);
    end
    $display("op we=%b f3=%b addr=%h wd=%h delay=%0d -> err=%b rdata=%h", we, f3, addr, wd, delay, exp_err, exp_rd);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_req_valid = 1'b1; i_req_we = 1'b1; i_req_funct3 = 3'b010;
    i_req_addr = 32'h1234; i_req_wdata = 32'hDEAD; i_mem_ack = 1'b1; i_mem_rdata = 32'hFFFF;
    repeat (3) @(negedge clk);
    n_checks++;
    if (o_req_ready !== 1'b1 || o_mem_req !== 1'b0 || o_mem_we !== 1'b0 || o_mem_addr !== 32'h0 ||
        o_mem_be !== 4'h0 || o_mem_wdata !== 32'h0 || o_rsp_valid !== 1'b0 ||
        o_rsp_rdata !== 32'h0 || o_rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got rdy=%b req=%b we=%b addr=%h be=%b wd=%h rv=%b rd=%h err=%b exp rdy=1 others 0",
               o_req_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata, o_rsp_valid, o_rsp_rdata, o_rsp_err);
    end
    i_req_valid = 1'b0; i_mem_ack = 1'b0;
    rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_directed();
    run_op(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0);
    run_op(1'b0, 3'b000, 32'h0000_2001, 32'h0, 32'h0000_8000, 1);
    run_op(1'b0, 3'b100, 32'h0000_2001, 32'h0, 32'h0000_8000, 2);
    run_op(1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_1234, 0);
    run_op(1'b0, 3'b010, 32'h0000_2000, 32'h0, 32'hCAFE_F00D, 5);
    run_op(1'b1, 3'b001, 32'h0000_2002, 32'h1234_5678, 32'h0, 3);
    run_op(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'hF00D_0001, 1);
  endtask

  task automatic test_illegal();
    run_op(1'b0, 3'b011, 32'h0000_4000, 32'h0, 32'h0, 0);
    run_op(1'b0, 3'b110, 32'h0000_4004, 32'h0, 32'h0, 0);
    run_op(1'b0, 3'b111, 32'h0000_4008, 32'h0, 32'h0, 0);
    run_op(1'b1, 3'b100, 32'h0000_400C, 32'h55, 32'h0, 0);
    run_op(1'b1, 3'b011, 32'h0000_4010, 32'h66, 32'h0, 0);
  endtask

  task automatic test_timeout();
    run_op(1'b0, 3'b010, 32'h0000_5000, 32'h0, 32'h1111_2222, 100);
    @(negedge clk);
    i_mem_ack = 1'b1; i_mem_rdata = 32'h9999_9999;
    @(negedge clk);
    i_mem_ack = 1'b0;
    n_checks++;
    if (o_rsp_valid !== 1'b0 || o_mem_req !== 1'b0 || o_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL stray_ack got rv=%b req=%b rdy=%b exp rv=0 req=0 rdy=1", o_rsp_valid, o_mem_req, o_req_ready);
    end
    run_op(1'b0, 3'b010, 32'h0000_5004, 32'h0, 32'h3333_4444, TB_TIMEOUT - 1);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    i_req_valid = 1'b1; i_req_we = 1'b0; i_req_funct3 = 3'b010; i_req_addr = 32'h0000_6000;
    @(negedge clk);
    i_req_valid = 1'b0;
    n_checks++;
    if (o_mem_req !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_setup mem_req got=%b exp=1", o_mem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_mem_req !== 1'b0 || o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got req=%b rdy=%b rv=%b exp req=0 rdy=1 rv=0", o_mem_req, o_req_ready, o_rsp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (o_rsp_valid !== 1'b0 || o_mem_req !== 1'b0) begin
        n_fail++; $display("FAIL abandoned_access cycle%0d got rv=%b req=%b exp 0 0", k, o_rsp_valid, o_mem_req);
      end
    end
    $display("mid-access reset abandoned");
  endtask

  task automatic test_misalign();
    run_op(1'b0, 3'b010, 32'h0000_3002, 32'h0, 32'hABCD_EF01, 1);
    run_op(1'b0, 3'b001, 32'h0000_3003, 32'h0, 32'h8765_4321, 0);
    run_op(1'b1, 3'b001, 32'h0000_3001, 32'h0000_BEEF, 32'h0, 0);
  endtask

  task automatic test_random();
    logic [2:0] f3;
    logic       we;
    int         dly;
    for (int t = 0; t < 40; t++) begin
      we = 1'($urandom);
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom);
      else if (we) f3 = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100; default: f3 = 3'b101;
        endcase
      end
      dly = ($urandom_range(0, 9) == 0) ? TB_TIMEOUT + 2 : int'($urandom_range(0, 4));
      run_op(we, f3, $urandom, $urandom, $urandom, dly);
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 6; t++) begin
      run_op(1'b0, 3'b000, 32'h0000_7000 + t, 32'h0, 32'h80C0_7F01 + (t * 32'h0101_0101), 0);
    end
  endtask

  initial begin
    i_req_valid = 1'b0; i_req_we = 1'b0; i_req_funct3 = 3'b000; i_req_addr = 32'h0;
    i_req_wdata = 32'h0; i_mem_ack = 1'b0; i_mem_rdata = 32'h0; rst_n = 1'b0;
    test_reset();
    test_directed();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_misalign();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
